// File: rtl/vector_lane_dispatcher.sv
// ---------------------------------------------------------------------------------------------
// vector_lane_dispatcher
//
// Initiator side of the lane op/start/done protocol. One vector command is accepted at a time
// over a valid/ready port. Its opcode, scalar operand and per-lane write data are captured and
// broadcast to every lane. A single-cycle start pulse follows. The block then waits until every
// lane has reported done; a lane may report on any cycle, and its done is remembered. For the
// read opcode, full rows of lane read data are gathered into a vlen_p-element buffer while the
// lanes work. The buffer is then streamed out in element order over a valid/ready/last port.
// A one-cycle cmd_done_o pulse marks the end of every command.
//
// Ports
//   clk_i          clock, single domain
//   reset_n_i      asynchronous active-low reset; the lanes must share this reset source
//   cmd_v_i        command valid
//   cmd_ready_o    command ready, high only while idle
//   cmd_op_i       opcode (4'b1000 read, 4'b1111 fma, 4'b1001 external write)
//   cmd_scalar_i   scalar operand
//   cmd_w_data_i   per-lane write data, lane i at [i*vdw_p +: vdw_p]
//   cmd_done_o     one-cycle pulse when the command has fully completed
//   lane_op_o      opcode to all lanes, held from accept through completion
//   lane_start_o   one-cycle start pulse to all lanes
//   lane_scalar_o  scalar to all lanes, held like lane_op_o
//   lane_w_data_o  per-lane write data, held like lane_op_o
//   lane_done_i    per-lane done
//   lane_v_i       per-lane read-data valid
//   lane_r_data_i  per-lane read data, lane i at [i*vdw_p +: vdw_p]
//   rd_v_o         read stream valid
//   rd_ready_i     read stream ready
//   rd_data_o      read stream element
//   rd_last_o      high together with element vlen_p-1
// ---------------------------------------------------------------------------------------------
module vector_lane_dispatcher #(
    parameter int unsigned vlen_p     = 8,
    parameter int unsigned vdw_p      = 8,
    parameter int unsigned lanes_p    = 4,
    parameter int unsigned op_width_p = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       cmd_v_i,
    output logic                       cmd_ready_o,
    input  logic [op_width_p-1:0]      cmd_op_i,
    input  logic [vdw_p-1:0]           cmd_scalar_i,
    input  logic [lanes_p*vdw_p-1:0]   cmd_w_data_i,
    output logic                       cmd_done_o,

    output logic [op_width_p-1:0]      lane_op_o,
    output logic                       lane_start_o,
    output logic [vdw_p-1:0]           lane_scalar_o,
    output logic [lanes_p*vdw_p-1:0]   lane_w_data_o,
    input  logic [lanes_p-1:0]         lane_done_i,
    input  logic [lanes_p-1:0]         lane_v_i,
    input  logic [lanes_p*vdw_p-1:0]   lane_r_data_i,

    output logic                       rd_v_o,
    input  logic                       rd_ready_i,
    output logic [vdw_p-1:0]           rd_data_o,
    output logic                       rd_last_o
);

    // -----------------------------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------------------------
    localparam int unsigned NumRows = vlen_p / lanes_p;
    localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned IdxW    = (vlen_p > 1) ? $clog2(vlen_p) : 1;

    localparam logic [op_width_p-1:0] OpRead  = op_width_p'(4'b1000);
    localparam logic [RowW-1:0]       RowMax  = RowW'(NumRows - 1);
    localparam logic [IdxW-1:0]       IdxLast = IdxW'(vlen_p - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StBusy,
        StDrain,
        StDone
    } state_e;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    state_e                     state_q, state_d;
    logic [op_width_p-1:0]      op_q, op_d;
    logic [vdw_p-1:0]           scalar_q, scalar_d;
    logic [lanes_p*vdw_p-1:0]   w_data_q, w_data_d;
    logic [lanes_p-1:0]         mask_q, mask_d;
    logic [RowW-1:0]            row_q, row_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [vdw_p-1:0]           rbuf_q [vlen_p];
    logic [vdw_p-1:0]           rbuf_d [vlen_p];

    // Done mask including this cycle's reports; exit is decided on this so a lane finishing
    // on the final cycle does not cost an extra cycle.
    logic [lanes_p-1:0]         mask_all;
    logic                       is_read;
    logic                       row_full;
    logic [IdxW-1:0]            row_base;

    assign mask_all = mask_q | lane_done_i;
    assign is_read  = (op_q == OpRead);
    // Only a row where every lane presents data is captured.
    assign row_full = &lane_v_i;
    assign row_base = IdxW'(lanes_p) * IdxW'(row_q);

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        scalar_d = scalar_q;
        w_data_d = w_data_q;
        mask_d   = mask_q;
        row_d    = row_q;
        idx_d    = idx_q;
        rbuf_d   = rbuf_q;

        case (state_q)
            StIdle: begin
                if (cmd_v_i) begin
                    state_d  = StIssue;
                    op_d     = cmd_op_i;
                    scalar_d = cmd_scalar_i;
                    w_data_d = cmd_w_data_i;
                    mask_d   = '0;
                    row_d    = '0;
                    idx_d    = '0;
                end
            end

            // Lanes see the start pulse here; their inputs are not yet meaningful.
            StIssue: begin
                state_d = StBusy;
            end

            StBusy: begin
                mask_d = mask_all;
                if (is_read && row_full) begin
                    for (int unsigned i = 0; i < lanes_p; i++) begin
                        rbuf_d[row_base + IdxW'(i)] = lane_r_data_i[i*vdw_p +: vdw_p];
                    end
                    // Extra rows beyond the last overwrite the last row.
                    if (row_q != RowMax) begin
                        row_d = row_q + RowW'(1);
                    end
                end
                if (&mask_all) begin
                    state_d = is_read ? StDrain : StDone;
                end
            end

            StDrain: begin
                if (rd_ready_i) begin
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            op_q     <= '0;
            scalar_q <= '0;
            w_data_q <= '0;
            mask_q   <= '0;
            row_q    <= '0;
            idx_q    <= '0;
            for (int unsigned e = 0; e < vlen_p; e++) begin
                rbuf_q[e] <= '0;
            end
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            scalar_q <= scalar_d;
            w_data_q <= w_data_d;
            mask_q   <= mask_d;
            row_q    <= row_d;
            idx_q    <= idx_d;
            for (int unsigned e = 0; e < vlen_p; e++) begin
                rbuf_q[e] <= rbuf_d[e];
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs, all decoded from registered state only
    // -----------------------------------------------------------------------------------------
    assign cmd_ready_o   = (state_q == StIdle);
    assign lane_start_o  = (state_q == StIssue);
    assign cmd_done_o    = (state_q == StDone);
    assign lane_op_o     = op_q;
    assign lane_scalar_o = scalar_q;
    assign lane_w_data_o = w_data_q;

    assign rd_v_o        = (state_q == StDrain);
    assign rd_data_o     = rbuf_q[idx_q];
    assign rd_last_o     = (idx_q == IdxLast);

endmodule

// File: tb/tb_vector_lane_dispatcher.sv
module tb_vector_lane_dispatcher;

    localparam int LANES = 4;
    localparam int VLEN  = 8;
    localparam int VDW   = 8;
    localparam int ROWS  = VLEN / LANES;

    logic                  clk;
    logic                  reset_n;
    logic                  cmd_v;
    logic                  cmd_ready;
    logic [3:0]            cmd_op;
    logic [VDW-1:0]        cmd_scalar;
    logic [LANES*VDW-1:0]  cmd_w_data;
    logic                  cmd_done;
    logic [3:0]            lane_op;
    logic                  lane_start;
    logic [VDW-1:0]        lane_scalar;
    logic [LANES*VDW-1:0]  lane_w_data;
    logic [LANES-1:0]      lane_done;
    logic [LANES-1:0]      lane_v;
    logic [LANES*VDW-1:0]  lane_r_data;
    logic                  rd_v;
    logic                  rd_ready;
    logic [VDW-1:0]        rd_data;
    logic                  rd_last;

    int checks = 0;
    int passes = 0;

    vector_lane_dispatcher #(
        .vlen_p     (VLEN),
        .vdw_p      (VDW),
        .lanes_p    (LANES),
        .op_width_p (4)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .cmd_v_i       (cmd_v),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (cmd_op),
        .cmd_scalar_i  (cmd_scalar),
        .cmd_w_data_i  (cmd_w_data),
        .cmd_done_o    (cmd_done),
        .lane_op_o     (lane_op),
        .lane_start_o  (lane_start),
        .lane_scalar_o (lane_scalar),
        .lane_w_data_o (lane_w_data),
        .lane_done_i   (lane_done),
        .lane_v_i      (lane_v),
        .lane_r_data_i (lane_r_data),
        .rd_v_o        (rd_v),
        .rd_ready_i    (rd_ready),
        .rd_data_o     (rd_data),
        .rd_last_o     (rd_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL idle_timeout: cmd_ready=%b required 1", cmd_ready);
        else passes++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_v = 1'b0; cmd_op = '0; cmd_scalar = '0; cmd_w_data = '0;
        lane_done = '0; lane_v = '0; lane_r_data = '0; rd_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({cmd_ready, lane_start, rd_v, cmd_done} !== 4'b1000)
            $display("FAIL reset_ctl: ready/start/rd_v/done=%b required 1000",
                     {cmd_ready, lane_start, rd_v, cmd_done});
        else passes++;
        checks++;
        if ({lane_op, lane_scalar, lane_w_data} !== '0)
            $display("FAIL reset_data: op=%h scalar=%h wdata=%h required 0",
                     lane_op, lane_scalar, lane_w_data);
        else passes++;
        reset_n = 1'b1;
        tick(); tick();
        checks++;
        if ({cmd_ready, lane_start, rd_v, cmd_done, lane_op} !== 8'b1000_0000)
            $display("FAIL idle_after_reset: ready/start/rd_v/done/op=%b required 10000000",
                     {cmd_ready, lane_start, rd_v, cmd_done, lane_op});
        else passes++;
    endtask

    // Op 0 accepted at edge T; lanes 0,1,3 done at T+6, lane 2 at T+9 -> done pulse at T+10.
    task automatic test_op_timing();
        wait_idle();
        cmd_v = 1'b1; cmd_op = 4'b0000; cmd_scalar = 8'($urandom); cmd_w_data = $urandom;
        tick();                                   // edge T, now cycle T+1
        cmd_v = 1'b0;
        checks++;
        if (lane_start !== 1'b1) $display("FAIL issue_start: start=%b required 1", lane_start);
        else passes++;
        // Lane inputs during ISSUE must be ignored.
        lane_done = 4'hF; lane_v = 4'hF;
        tick();
        lane_v = '0;
        for (int c = 2; c <= 9; c++) begin
            checks++;
            if ({lane_start, cmd_done, cmd_ready, lane_op} !== 7'b000_0000)
                $display("FAIL busy_T%0d: start/done/ready/op=%b required 0000000",
                         c, {lane_start, cmd_done, cmd_ready, lane_op});
            else passes++;
            lane_done = (c == 6) ? 4'b1011 : (c == 9) ? 4'b0100 : 4'b0000;
            tick();
        end
        lane_done = '0;
        checks++;
        if (cmd_done !== 1'b1) $display("FAIL done_T10: cmd_done=%b required 1", cmd_done);
        else passes++;
        tick();
        checks++;
        if ({cmd_done, cmd_ready} !== 2'b01)
            $display("FAIL idle_T11: done/ready=%b required 01", {cmd_done, cmd_ready});
        else passes++;
    endtask

    // Random non-read ops: each lane pulses done once at a random BUSY offset; the command
    // completes the cycle after the latest lane.
    task automatic test_random_ops(input int n);
        for (int t = 0; t < n; t++) begin
            int d [LANES];
            int lat = 0;
            logic [3:0] op;
            logic [VDW-1:0] sc;
            logic [LANES*VDW-1:0] wd;
            do op = 4'($urandom); while (op == 4'b1000);
            sc = 8'($urandom); wd = $urandom;
            for (int l = 0; l < LANES; l++) begin
                d[l] = $urandom_range(0, 5);
                if (d[l] > lat) lat = d[l];
            end
            wait_idle();
            cmd_v = 1'b1; cmd_op = op; cmd_scalar = sc; cmd_w_data = wd;
            tick();
            cmd_v = 1'b0; cmd_op = ~op; cmd_scalar = ~sc; cmd_w_data = ~wd;
            tick();
            for (int c = 0; c <= lat; c++) begin
                checks++;
                if ({cmd_done, lane_op, lane_scalar, lane_w_data} !== {1'b0, op, sc, wd})
                    $display("FAIL rnd_busy%0d: done=%b op=%h sc=%h wd=%h required 0 %h %h %h",
                             t, cmd_done, lane_op, lane_scalar, lane_w_data, op, sc, wd);
                else passes++;
                for (int l = 0; l < LANES; l++) lane_done[l] = (c == d[l]);
                tick();
            end
            lane_done = '0;
            checks++;
            if ({cmd_done, lane_op} !== {1'b1, op})
                $display("FAIL rnd_done%0d: done=%b op=%h required 1 %h", t, cmd_done, lane_op, op);
            else passes++;
            tick();
        end
    endtask

    // One read command. ready_mode: 0 always ready, 1 pattern 1,0,0,1,0,1, 2 random.
    // rnd: random rows, partial-valid gaps, staggered dones and possible surplus rows.
    // abort_after >= 0: assert reset once that many elements have been handshaken.
    task automatic read_cmd(input int ready_mode, input bit rnd, input int abort_after);
        logic [VDW-1:0]       exp_elem [VLEN];
        logic [LANES*VDW-1:0] rowv;
        logic [VDW-1:0]       sc;
        logic [LANES*VDW-1:0] wd;
        logic [LANES-1:0]     held;
        int nfull, hs, guard, pc, r;
        bit rdy, v_s;
        bit pat [6] = '{1, 0, 0, 1, 0, 1};

        wait_idle();
        sc = 8'($urandom); wd = $urandom;
        cmd_v = 1'b1; cmd_op = 4'b1000; cmd_scalar = sc; cmd_w_data = wd;
        tick();
        cmd_v = 1'b0;
        checks++;
        if ({lane_start, lane_op, lane_scalar, lane_w_data} !== {1'b1, 4'b1000, sc, wd})
            $display("FAIL rd_issue: start=%b op=%h sc=%h wd=%h required 1 8 %h %h",
                     lane_start, lane_op, lane_scalar, lane_w_data, sc, wd);
        else passes++;
        tick();

        nfull = rnd ? $urandom_range(ROWS, ROWS + 1) : ROWS;
        held  = 4'(1 << $urandom_range(0, LANES - 1));
        for (int k = 0; k < nfull; k++) begin
            int gaps = rnd ? $urandom_range(0, 3) : 0;
            for (int g = 0; g < gaps; g++) begin
                lane_v      = 4'($urandom_range(0, 14));
                lane_r_data = $urandom;
                lane_done   = 4'($urandom) & ~held;
                tick();
            end
            for (int l = 0; l < LANES; l++)
                rowv[l*VDW +: VDW] = rnd ? 8'($urandom) : 8'(8'h10 + 4 * k + l);
            r = (k < ROWS) ? k : ROWS - 1;
            for (int l = 0; l < LANES; l++) exp_elem[l + LANES * r] = rowv[l*VDW +: VDW];
            lane_v      = 4'hF;
            lane_r_data = rowv;
            lane_done   = (k == nfull - 1) ? 4'hF : (rnd ? (4'($urandom) & ~held) : 4'h0);
            tick();
        end
        lane_v = '0; lane_done = '0; lane_r_data = '0;

        hs = 0; guard = 0; pc = 0;
        while (hs < VLEN && guard < 100) begin
            if (abort_after >= 0 && hs == abort_after) begin
                reset_n = 1'b0;
                #1;
                checks++;
                if ({rd_v, cmd_done, cmd_ready} !== 3'b001)
                    $display("FAIL abort_now: rd_v/done/ready=%b required 001",
                             {rd_v, cmd_done, cmd_ready});
                else passes++;
                tick();
                reset_n = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    tick();
                    checks++;
                    if ({rd_v, cmd_done} !== 2'b00)
                        $display("FAIL abort_after%0d: rd_v/done=%b required 00", c, {rd_v, cmd_done});
                    else passes++;
                end
                rd_ready = 1'b0;
                return;
            end
            v_s = rd_v;
            checks++;
            if (v_s !== 1'b1 || cmd_done !== 1'b0)
                $display("FAIL drain_v%0d: rd_v/done=%b required 10", hs, {rd_v, cmd_done});
            else passes++;
            if (v_s) begin
                checks++;
                if (rd_data !== exp_elem[hs] || rd_last !== (hs == VLEN - 1))
                    $display("FAIL rd_elem%0d: data=%h last=%b required %h %b",
                             hs, rd_data, rd_last, exp_elem[hs], (hs == VLEN - 1));
                else passes++;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[pc % 6];
                default: rdy = 1'($urandom);
            endcase
            if (v_s) pc++;
            rd_ready = rdy;
            tick();
            if (v_s && rdy) hs++;
            guard++;
        end
        rd_ready = 1'b0;
        checks++;
        if (hs != VLEN) $display("FAIL drain_timeout: elements=%0d required %0d", hs, VLEN);
        else passes++;
        checks++;
        if ({cmd_done, rd_v} !== 2'b10)
            $display("FAIL rd_done: done/rd_v=%b required 10", {cmd_done, rd_v});
        else passes++;
        tick();
        checks++;
        if ({cmd_done, cmd_ready} !== 2'b01)
            $display("FAIL rd_idle: done/ready=%b required 01", {cmd_done, cmd_ready});
        else passes++;
    endtask

    task automatic test_read();
        read_cmd(0, 1'b0, -1);
    endtask

    task automatic test_read_stall();
        read_cmd(1, 1'b0, -1);
    endtask

    task automatic test_random_reads(input int n);
        for (int t = 0; t < n; t++) read_cmd(2, 1'b1, -1);
    endtask

    // A new request held during BUSY must wait for the first idle cycle.
    task automatic test_busy_hold();
        wait_idle();
        cmd_v = 1'b1; cmd_op = 4'b1111; cmd_scalar = 8'h5A; cmd_w_data = 32'h1234_5678;
        tick();
        cmd_op = 4'b0101;
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({cmd_ready, lane_op} !== {1'b0, 4'b1111})
                $display("FAIL hold_busy%0d: ready=%b op=%h required 0 f", c, cmd_ready, lane_op);
            else passes++;
            tick();
        end
        lane_done = 4'hF;
        tick();
        lane_done = '0;
        checks++;
        if ({cmd_done, cmd_ready, lane_op} !== {2'b10, 4'b1111})
            $display("FAIL hold_done: done=%b ready=%b op=%h required 1 0 f",
                     cmd_done, cmd_ready, lane_op);
        else passes++;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL hold_idle: ready=%b required 1", cmd_ready);
        else passes++;
        tick();
        cmd_v = 1'b0;
        checks++;
        if ({lane_start, lane_op} !== {1'b1, 4'b0101})
            $display("FAIL hold_accept: start=%b op=%h required 1 5", lane_start, lane_op);
        else passes++;
        tick();
        lane_done = 4'hF;
        tick();
        lane_done = '0;
        checks++;
        if (cmd_done !== 1'b1) $display("FAIL hold_done2: done=%b required 1", cmd_done);
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        read_cmd(0, 1'b1, 3);
        read_cmd(0, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_op_timing();
        test_read();
        test_read_stall();
        test_busy_hold();
        test_reset_mid();
        test_random_ops(8);
        test_random_reads(8);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
